fp_addsub_align_module: RTL and testbench

Operand-alignment stage of the single-precision floating-point adder/subtractor. Takes the two sign-stripped operand magnitudes, picks the larger, reports the exponent difference, and right-shifts the smaller operand's significand into a wide field. Downstream stages can then add or subtract the significands directly. Sits between the operand-unpack stage and the significand add/normalise stage; one register stage.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_addsub_align_module_if.sv | 13 +
 rtl/fp_align_shifter.sv | 26 ++
 rtl/fp_addsub_align_module.sv | 63 ++++++
 tb/tb_fp_addsub_align_module.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared widths and field helpers for the floating-point add/sub datapath.
// The alignment stage uses them to build significands and effective exponents.
package fp_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MAN_W   = 25;
    localparam int ALIGN_W = 50;
    localparam int OP_W    = EXP_W + FRAC_W;
    localparam int SHAMT_W = EXP_W;

    // Zero exponent means zero/subnormal, so there is no implicit leading one.
    function automatic logic hidden_bit(input logic [EXP_W-1:0] e);
        return |e;
    endfunction

    // Subnormals scale like exponent 1.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    function automatic logic [MAN_W-1:0] make_man(input logic [EXP_W-1:0] e,
                                                  input logic [FRAC_W-1:0] f);
        return {1'b0, hidden_bit(e), f};
    endfunction
endpackage

// File: rtl/fp_addsub_align_module_if.sv
// Operand/result bundle of the alignment stage: the upstream unpack stage
// drives the magnitudes, the alignment stage returns the aligned significands.
interface fp_addsub_align_module_if;
    logic [fp_pkg::OP_W-1:0]    A;
    logic [fp_pkg::OP_W-1:0]    B;
    logic [fp_pkg::EXP_W-1:0]   Es;
    logic                       MaxAB;
    logic [fp_pkg::MAN_W-1:0]   Mmax;
    logic [fp_pkg::ALIGN_W-1:0] Mmin;

    modport master (output A, B, input Es, MaxAB, Mmax, Mmin);
    modport slave  (input A, B, output Es, MaxAB, Mmax, Mmin);
endinterface

// File: rtl/fp_align_shifter.sv
// Combinational logarithmic right shifter for the smaller significand.
// Zero-fill, no sticky; amounts past the field width flush the result to zero.
module fp_align_shifter
    import fp_pkg::*;
(
    input  logic [ALIGN_W-1:0] din,
    input  logic [SHAMT_W-1:0] amt,
    output logic [ALIGN_W-1:0] dout
);
    localparam int LVLS = 6;

    logic [ALIGN_W-1:0] stg [0:LVLS];

    function automatic logic shift_saturates(input logic [SHAMT_W-1:0] a);
        return a >= SHAMT_W'(ALIGN_W);
    endfunction

    // Level i shifts by 2**i; the top amount bits only matter through saturation.
    always_comb begin
        stg[0] = din;
        for (int i = 0; i < LVLS; i++) begin
            stg[i+1] = amt[i] ? (stg[i] >> (1 << i)) : stg[i];
        end
        dout = shift_saturates(amt) ? '0 : stg[LVLS];
    end
endmodule

// File: rtl/fp_addsub_align_module.sv
// Alignment stage of the FP adder: picks the larger magnitude, reports the
// exponent gap and right-aligns the smaller significand, one register stage.
module fp_addsub_align_module
    import fp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    fp_addsub_align_module_if.slave  io
);
    logic                maxab_p0;
    logic [OP_W-1:0]     max_op_p0;
    logic [OP_W-1:0]     min_op_p0;
    logic [EXP_W-1:0]    emax_p0;
    logic [EXP_W-1:0]    emin_p0;
    logic [EXP_W-1:0]    es_p0;
    logic [MAN_W-1:0]    mmax_p0;
    logic [ALIGN_W-1:0]  mmin_base_p0;
    logic [ALIGN_W-1:0]  mmin_p0;

    logic [EXP_W-1:0]    es_p1;
    logic                maxab_p1;
    logic [MAN_W-1:0]    mmax_p1;
    logic [ALIGN_W-1:0]  mmin_p1;

    // Stage 0: compare, swap, exponent difference and alignment shift.
    always_comb begin
        maxab_p0     = io.B > io.A;
        max_op_p0    = maxab_p0 ? io.B : io.A;
        min_op_p0    = maxab_p0 ? io.A : io.B;
        emax_p0      = eff_exp(max_op_p0[OP_W-1:FRAC_W]);
        emin_p0      = eff_exp(min_op_p0[OP_W-1:FRAC_W]);
        es_p0        = emax_p0 - emin_p0;
        mmax_p0      = make_man(max_op_p0[OP_W-1:FRAC_W], max_op_p0[FRAC_W-1:0]);
        mmin_base_p0 = {make_man(min_op_p0[OP_W-1:FRAC_W], min_op_p0[FRAC_W-1:0]),
                        {(ALIGN_W-MAN_W){1'b0}}};
    end

    fp_align_shifter u_shifter (
        .din  (mmin_base_p0),
        .amt  (es_p0),
        .dout (mmin_p0)
    );

    // Stage 1: output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            es_p1    <= '0;
            maxab_p1 <= 1'b0;
            mmax_p1  <= '0;
            mmin_p1  <= '0;
        end else begin
            es_p1    <= es_p0;
            maxab_p1 <= maxab_p0;
            mmax_p1  <= mmax_p0;
            mmin_p1  <= mmin_p0;
        end
    end

    assign io.Es    = es_p1;
    assign io.MaxAB = maxab_p1;
    assign io.Mmax  = mmax_p1;
    assign io.Mmin  = mmin_p1;
endmodule

// File: tb/tb_fp_addsub_align_module.sv
// Bench for the FP alignment stage: directed vectors with literal results,
// then a randomized stream with mid-stream resets against a numeric model.
module tb_fp_addsub_align_module;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp_addsub_align_module_if io ();

    fp_addsub_align_module dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint es;
        longint maxab;
        longint mmax;
        longint mmin;
    } res_t;

    res_t exp_r;
    bit   exp_vld = 1'b0;

    // Numeric reading of the operands: value = sig * 2**(eff_exp) up to a common scale.
    function automatic res_t model(input longint a, input longint b);
        res_t   r;
        longint ea, eb, sa, sb, emx, emn, smx, smn;
        ea = (a >> 23) & 255;
        eb = (b >> 23) & 255;
        sa = (a & 64'h7FFFFF) + ((ea != 0) ? 64'h800000 : 0);
        sb = (b & 64'h7FFFFF) + ((eb != 0) ? 64'h800000 : 0);
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        r.maxab = (b > a) ? 1 : 0;
        if (r.maxab == 1) begin
            emx = eb; smx = sb; emn = ea; smn = sa;
        end else begin
            emx = ea; smx = sa; emn = eb; smn = sb;
        end
        r.es   = emx - emn;
        r.mmax = smx;
        r.mmin = (r.es >= 50) ? 0 : ((smn * (64'd1 << 25)) / (64'd1 << r.es));
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic check_lit(input string nm, input longint es, input longint maxab,
                             input longint mmax, input longint mmin);
        cmp({nm, ".Es"},    64'(io.Es),    es);
        cmp({nm, ".MaxAB"}, 64'(io.MaxAB), maxab);
        cmp({nm, ".Mmax"},  64'(io.Mmax),  mmax);
        cmp({nm, ".Mmin"},  64'(io.Mmin),  mmin);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_r = '{0, 0, 0, 0};
        end else begin
            exp_r = model(longint'(io.A), longint'(io.B));
        end
        exp_vld = 1'b1;
    end

    always @(negedge clk) begin
        if (exp_vld) begin
            cmp("model.Es",    64'(io.Es),    exp_r.es);
            cmp("model.MaxAB", 64'(io.MaxAB), exp_r.maxab);
            cmp("model.Mmax",  64'(io.Mmax),  exp_r.mmax);
            cmp("model.Mmin",  64'(io.Mmin),  exp_r.mmin);
        end
    end

    longint vec_a   [4] = '{64'h40000001, 64'h3F800001, 64'h41000002, 64'h00000001};
    longint vec_b   [4] = '{64'h40000001, 64'h40400002, 64'h2EC00011, 64'h40C0100D};
    longint vec_es  [4] = '{0, 1, 37, 128};
    longint vec_mx  [4] = '{0, 1, 0, 1};
    longint vec_mmx [4] = '{64'h0800001, 64'h0C00002, 64'h0800002, 64'h0C0100D};
    longint vec_mmn [4] = '{64'h1000002000000, 64'h800001000000, 64'hC00, 0};

    function automatic logic [30:0] rand_op();
        logic [30:0] v;
        v = 31'($urandom);
        case ($urandom_range(0, 3))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'($urandom_range(120, 135));
            2: v[30:23] = 8'hFF;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        string nm;
        logic [30:0] ra;

        rst  = 1'b1;
        io.A = 31'h40000001;
        io.B = 31'h3F800000;
        @(negedge clk);
        check_lit("reset", 0, 0, 0, 0);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io.A = 31'(vec_a[i]);
            io.B = 31'(vec_b[i]);
            @(negedge clk);
            nm = $sformatf("vec%0d", i + 2);
            check_lit(nm, vec_es[i], vec_mx[i], vec_mmx[i], vec_mmn[i]);
        end

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            ra  = rand_op();
            io.A = ra;
            case ($urandom_range(0, 5))
                0: io.B = ra;
                1: io.B = ra + 31'($urandom_range(0, 3)) - 31'd1;
                default: io.B = rand_op();
            endcase
            @(negedge clk);
        end

        rst = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
